// File: rtl/vrf_wr_decoder_pkg.sv
// Shared types and helpers for the vector register file write decoder.
package vrf_pkg;

  typedef enum logic {IDLE, BURST} fsm_state_e;

  localparam int LMUL_W    = 2;
  localparam int MAX_GROUP = 8;
  localparam int CNT_W     = $clog2(MAX_GROUP);

  // True when addr is a multiple of the group size 2^lmul.
  function automatic logic is_aligned(input logic [31:0] addr, input logic [LMUL_W-1:0] lmul);
    logic [31:0] mask;
    mask = (32'd1 << lmul) - 32'd1;
    return (addr & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/vrf_wr_decoder_if.sv
// Write-port bundle: one valid/ready beat per port, carrying base register and group size.
interface vrf_wr_decoder_if
  import vrf_pkg::*;
#(
  parameter int NUM_REG   = 32,
  parameter int NUM_PORTS = 2
);
  localparam int AW = $clog2(NUM_REG);

  logic [NUM_PORTS-1:0]             wr_valid;
  logic [NUM_PORTS-1:0]             wr_ready;
  logic [NUM_PORTS-1:0][AW-1:0]     wr_addr;
  logic [NUM_PORTS-1:0][LMUL_W-1:0] wr_lmul;

  modport master (output wr_valid, output wr_addr, output wr_lmul, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_lmul, output wr_ready);
endinterface

// File: rtl/vrf_wr_decoder_port_seq.sv
// Per-port group sequencer: expands a register-group write into single-register beats.
module vrf_wr_port_seq
  import vrf_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_accept,
  input  logic [AW-1:0]     i_addr,
  input  logic [LMUL_W-1:0] i_lmul,
  output logic [AW-1:0]     o_target,
  output logic              o_drop,
  output logic              o_busy
);

  fsm_state_e        r_state, w_state_nxt;
  logic [AW-1:0]     r_base,  w_base_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [LMUL_W-1:0] r_lmul,  w_lmul_nxt;
  logic [CNT_W-1:0]  w_last_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_cnt   <= '0;
      r_lmul  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lmul  <= w_lmul_nxt;
    end
  end

  // Group size is latched on the first beat; later beats ignore i_lmul.
  assign w_last_cnt = CNT_W'((4'd1 << r_lmul) - 4'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_cnt_nxt   = r_cnt;
    w_lmul_nxt  = r_lmul;
    case (r_state)
      IDLE: begin
        if (i_accept && !o_drop && i_lmul != '0) begin
          w_state_nxt = BURST;
          w_base_nxt  = i_addr;
          w_cnt_nxt   = CNT_W'(1);
          w_lmul_nxt  = i_lmul;
        end
      end
      BURST: begin
        if (i_accept) begin
          if (r_cnt == w_last_cnt) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Base is aligned to the group size, so base + cnt never carries out.
  always_comb begin
    o_busy   = (r_state == BURST);
    o_drop   = (r_state == IDLE) && !is_aligned(32'(i_addr), i_lmul);
    o_target = (r_state == BURST) ? (r_base + AW'(r_cnt)) : i_addr;
  end

endmodule

// File: rtl/vrf_wr_decoder.sv
// Multi-port VRF write decoder: group sequencing per port, fixed-priority conflict resolution,
// registered per-register write enable and source select.
module vrf_wr_decoder
  import vrf_pkg::*;
#(
  parameter int NUM_REG   = 32,
  parameter int NUM_PORTS = 2,
  localparam int AW = $clog2(NUM_REG),
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  vrf_wr_decoder_if.slave             wr,
  output logic [NUM_REG-1:0]          reg_wen,
  output logic [NUM_REG-1:0][PW-1:0]  reg_src,
  output logic [NUM_PORTS-1:0]        busy,
  output logic [NUM_PORTS-1:0]        err
);

  logic [NUM_PORTS-1:0][AW-1:0]  w_tgt;
  logic [NUM_PORTS-1:0]          w_drop;
  logic [NUM_PORTS-1:0]          w_ready;
  logic [NUM_PORTS-1:0]          w_acc;
  logic [NUM_REG-1:0]            w_wen_nxt;
  logic [NUM_REG-1:0][PW-1:0]    w_src_nxt;
  logic [NUM_PORTS-1:0]          w_err_nxt;
  logic [NUM_REG-1:0]            r_wen;
  logic [NUM_REG-1:0][PW-1:0]    r_src;
  logic [NUM_PORTS-1:0]          r_err;

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_port
      vrf_wr_port_seq #(.AW(AW)) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_accept (w_acc[g]),
        .i_addr   (wr.wr_addr[g]),
        .i_lmul   (wr.wr_lmul[g]),
        .o_target (w_tgt[g]),
        .o_drop   (w_drop[g]),
        .o_busy   (busy[g])
      );
    end
  endgenerate

  // Lowest index wins; dropped (misaligned) beats neither block nor get blocked.
  always_comb begin
    w_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_ready[p] = wr.wr_valid[p];
      if (!w_drop[p]) begin
        for (int q = 0; q < p; q++) begin
          if (wr.wr_valid[q] && !w_drop[q] && w_tgt[q] == w_tgt[p]) w_ready[p] = 1'b0;
        end
      end
    end
  end

  assign wr.wr_ready = w_ready;
  assign w_acc       = wr.wr_valid & w_ready;

  always_comb begin
    w_wen_nxt = '0;
    w_src_nxt = '0;
    w_err_nxt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_acc[p] && w_drop[p]) begin
        w_err_nxt[p] = 1'b1;
      end else if (w_acc[p]) begin
        w_wen_nxt[w_tgt[p]] = 1'b1;
        w_src_nxt[w_tgt[p]] = PW'(p);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen <= '0;
      r_src <= '0;
      r_err <= '0;
    end else begin
      r_wen <= w_wen_nxt;
      r_src <= w_src_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign reg_wen = r_wen;
  assign reg_src = r_src;
  assign err     = r_err;

endmodule

// File: tb/tb_vrf_wr_decoder.sv
// Directed bench for vrf_wr_decoder with hand-computed expectations.
module tb_vrf_wr_decoder;
  localparam int NUM_REG   = 32;
  localparam int NUM_PORTS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REG-1:0]   reg_wen;
  logic [NUM_REG-1:0]   reg_src;
  logic [NUM_PORTS-1:0] busy, err;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vrf_wr_decoder_if #(.NUM_REG(NUM_REG), .NUM_PORTS(NUM_PORTS)) wif ();

  vrf_wr_decoder #(.NUM_REG(NUM_REG), .NUM_PORTS(NUM_PORTS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wif),
    .reg_wen (reg_wen),
    .reg_src (reg_src),
    .busy    (busy),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; leave time 1 after it so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [1:0] l0,
                       input logic [4:0] a1, input logic [1:0] l1);
    wif.wr_valid   = v;
    wif.wr_addr[0] = a0;
    wif.wr_lmul[0] = l0;
    wif.wr_addr[1] = a1;
    wif.wr_lmul[1] = l1;
    #1;
  endtask

  initial begin
    drive(2'b00, 5'd0, 2'd0, 5'd0, 2'd0);
    #20;
    chk("rst_wen", 64'(reg_wen), 64'h0);
    chk("rst_src", 64'(reg_src), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_ready", 64'(wif.wr_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single write, port 0 to register 5
    drive(2'b01, 5'd5, 2'd0, 5'd0, 2'd0);
    chk("single_ready", 64'(wif.wr_ready), 64'h1);
    step();
    chk("single_wen", 64'(reg_wen), 64'h20);
    chk("single_src", 64'(reg_src), 64'h0);
    chk("single_busy", 64'(busy), 64'h0);
    drive(2'b00, 5'd0, 2'd0, 5'd0, 2'd0);
    step();
    chk("single_wen_clr", 64'(reg_wen), 64'h0);

    // Group of 4 on port 1 starting at register 8
    drive(2'b10, 5'd0, 2'd0, 5'd8, 2'd2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("grp4_ready%0d", k), 64'(wif.wr_ready), 64'h2);
      step();
      chk($sformatf("grp4_wen%0d", k), 64'(reg_wen), 64'h1 << (8 + k));
      chk($sformatf("grp4_src%0d", k), 64'(reg_src), 64'h1 << (8 + k));
      chk($sformatf("grp4_busy%0d", k), 64'(busy), (k < 3) ? 64'h2 : 64'h0);
    end
    drive(2'b00, 5'd0, 2'd0, 5'd0, 2'd0);
    step();
    chk("grp4_idle_wen", 64'(reg_wen), 64'h0);

    // Same-target conflict: port 0 wins, port 1 follows
    drive(2'b11, 5'd12, 2'd0, 5'd12, 2'd0);
    chk("conf_ready", 64'(wif.wr_ready), 64'h1);
    step();
    chk("conf_wen0", 64'(reg_wen), 64'h1000);
    chk("conf_src0", 64'(reg_src), 64'h0);
    drive(2'b10, 5'd12, 2'd0, 5'd12, 2'd0);
    chk("conf_ready1", 64'(wif.wr_ready), 64'h2);
    step();
    chk("conf_wen1", 64'(reg_wen), 64'h1000);
    chk("conf_src1", 64'(reg_src), 64'h1000);

    // Distinct targets accepted together
    drive(2'b11, 5'd3, 2'd0, 5'd4, 2'd0);
    chk("dist_ready", 64'(wif.wr_ready), 64'h3);
    step();
    chk("dist_wen", 64'(reg_wen), 64'h18);
    chk("dist_src", 64'(reg_src), 64'h10);

    // Misaligned start on port 0
    drive(2'b01, 5'd6, 2'd2, 5'd0, 2'd0);
    chk("mis_ready", 64'(wif.wr_ready), 64'h1);
    step();
    chk("mis_err", 64'(err), 64'h1);
    chk("mis_wen", 64'(reg_wen), 64'h0);
    chk("mis_busy", 64'(busy), 64'h0);
    drive(2'b00, 5'd0, 2'd0, 5'd0, 2'd0);
    step();
    chk("mis_err_clr", 64'(err), 64'h0);

    // Misaligned beat neither blocks a higher port nor loses to it
    drive(2'b11, 5'd6, 2'd2, 5'd6, 2'd0);
    chk("mis_conf_ready", 64'(wif.wr_ready), 64'h3);
    step();
    chk("mis_conf_wen", 64'(reg_wen), 64'h40);
    chk("mis_conf_src", 64'(reg_src), 64'h40);
    chk("mis_conf_err", 64'(err), 64'h1);

    // 8-register group at 16 with a 3-cycle stall after beat 2
    drive(2'b01, 5'd16, 2'd3, 5'd0, 2'd0);
    step();
    chk("stall_wen0", 64'(reg_wen), 64'h1_0000);
    chk("stall_busy0", 64'(busy), 64'h1);
    step();
    chk("stall_wen1", 64'(reg_wen), 64'h2_0000);
    drive(2'b00, 5'd3, 2'd0, 5'd0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall_hold_wen%0d", k), 64'(reg_wen), 64'h0);
      chk($sformatf("stall_hold_busy%0d", k), 64'(busy), 64'h1);
    end
    drive(2'b01, 5'd3, 2'd0, 5'd0, 2'd0);
    chk("resume_ready", 64'(wif.wr_ready), 64'h1);
    step();
    chk("resume_wen", 64'(reg_wen), 64'h4_0000);
    chk("resume_busy", 64'(busy), 64'h1);

    // Reset mid-group
    rst_n = 1'b0;
    #1;
    chk("mrst_wen", 64'(reg_wen), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    chk("mrst_err", 64'(err), 64'h0);
    drive(2'b00, 5'd0, 2'd0, 5'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(2'b01, 5'd5, 2'd0, 5'd0, 2'd0);
    step();
    chk("post_rst_wen", 64'(reg_wen), 64'h20);
    chk("post_rst_busy", 64'(busy), 64'h0);
    drive(2'b00, 5'd0, 2'd0, 5'd0, 2'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vrf_wr_decoder.md
# vrf_wr_decoder

Multi-port, register-group-aware write decoder for the vector register file. Each write port hands over one beat per valid/ready handshake. A per-port state machine expands a register-group write of 1, 2, 4 or 8 registers into consecutive single-register beats. Same-register conflicts between ports are resolved by fixed priority, and the decoder drives a registered one-hot write-enable plus source-port select for every register.

## Interface

Parameters:
- NUM_REG, 32, number of vector registers; power of two, ≥ 8
- NUM_PORTS, 2, number of write ports; ≥ 1
- localparam AW = $clog2(NUM_REG); PW = max(1, $clog2(NUM_PORTS))

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  NUM_PORTS  beat request per port
- wr_ready  out  NUM_PORTS  beat accepted this cycle (combinational)
- wr_addr  in  NUM_PORTS×AW  base register; sampled only on a group's first beat
- wr_lmul  in  NUM_PORTS×2  log2 group size (0..3 → 1,2,4,8); sampled only on the first beat
- reg_wen  out  NUM_REG  registered one-hot-per-register write enable
- reg_src  out  NUM_REG×PW  registered source port for each enabled register; 0 where not enabled
- busy  out  NUM_PORTS  port is mid-group (state BURST)
- err  out  NUM_PORTS  registered one-cycle pulse: misaligned group start dropped

## Operation

- Each port has an FSM with two states, IDLE and BURST, plus a base register (AW bits) and a beat counter (3 bits).
- IDLE target = wr_addr[p]. BURST target = base + cnt. Base is aligned, so the sum never wraps.
- Accepted beat = wr_valid & wr_ready.
- IDLE, accepted, wr_lmul = 0: single write. Stay in IDLE.
- IDLE, accepted, wr_lmul = L > 0, wr_addr aligned to 2^L: write wr_addr, latch base ← wr_addr, cnt ← 1, go to BURST.
- IDLE, accepted, wr_addr not aligned to 2^L: beat is consumed with no write. err[p] pulses next cycle. Stay in IDLE.
- BURST, accepted: write base + cnt, cnt ← cnt + 1. When cnt = 2^L − 1, return to IDLE.
- BURST, not accepted: hold all state. wr_addr and wr_lmul are ignored.
- Conflict: if two or more valid ports have the same target register, the lowest-index port wins. Losing ports see wr_ready = 0 and hold state.
- Misaligned-start beats never cause a conflict and never lose one.
- Non-conflicting ports are all accepted in the same cycle.
- wr_ready[p] = wr_valid[p] & no lower-index valid port with the same non-dropped target. It never depends on wr_ready of any port.
- Upstream rules:
  - Hold wr_valid and its fields stable until accepted.
  - Dropping wr_valid mid-BURST is legal; the state is held.
- busy[p] = (state == BURST).

## Timing

- Reset (async assert, sync deassert by system): every FSM to IDLE, base and cnt to 0, reg_wen, reg_src and err to 0. busy = 0. wr_ready = 0 while wr_valid = 0.
- Reset mid-BURST abandons the group; there are no partial-group side effects after reset.
- Latency: a beat accepted in cycle N produces reg_wen/reg_src in cycle N+1, valid for exactly one cycle.
- Throughput: one beat per port per cycle when there is no conflict. An 8-register group takes 8 accepted beats.
- busy rises the cycle after the first beat of a group with L > 0 is accepted. It falls the cycle after the last beat is accepted.
- A single-beat write or a new group may be accepted on the cycle immediately after the last beat of a group.
- reg_wen may have up to NUM_PORTS bits set in one cycle, always for distinct registers.

## Structure

- Package vrf_pkg: typedef fsm_state_e {IDLE, BURST}; LMUL_W = 2; MAX_GROUP = 8; function is_aligned(addr, lmul).
- Sub-module vrf_wr_port_seq: one instance per port. It owns the FSM, base and cnt, and emits the target and a drop flag.
- Top level holds the priority conflict resolver, the registered reg_wen/reg_src, and the err registers.

## Test plan

- Single write: port 0, addr 5, lmul 0 → ready same cycle; next cycle reg_wen = 1<<5, reg_src[5] = 0, busy = 0.
- Group of 4: port 1, addr 8, lmul 2, valid held 4 cycles → reg_wen = bit 8, 9, 10, 11 on successive cycles, reg_src = 1 each time; busy high for cycles 2–4.
- Conflict: port 0 target 12 and port 1 target 12 → ready = 2'b01; port 1 is written to 12 the cycle after port 0 drops valid. Distinct targets 3 and 4 → both accepted, reg_wen = 0x18.
- Misaligned: port 0, addr 6, lmul 2 → ready = 1, err[0] = 1 next cycle, reg_wen = 0, busy = 0.
- Stall and reset: port 0 group addr 16, lmul 3, valid dropped after beat 2 for 3 cycles → busy held; resumes at register 18. Then assert rst_n = 0 mid-group → all outputs 0 immediately, FSM back in IDLE.
